// File: rtl/gerador_de_imediato_pkg.sv
// Shared definitions for the immediate generator.
//   MODE_*   : encodings of the 2-bit extension mode field
//   state_t  : prefix FSM states (IDLE = nothing pending, PFX = prefix pending)
//   sat_len  : saturating width accumulator for the prefix length
package gerador_de_imediato_pkg;

  localparam logic [1:0] MODE_SEXT = 2'b00;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_BR   = 2'b10;
  localparam logic [1:0] MODE_PFX  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PFX  = 1'b1
  } state_t;

  // Length of the accumulated constant never exceeds the operand width;
  // anything beyond that has already been shifted out.
  function automatic int unsigned sat_len(input int unsigned len,
                                          input int unsigned add,
                                          input int unsigned cap);
    return (len + add > cap) ? cap : len + add;
  endfunction

endpackage

// File: rtl/gerador_de_imediato_if.sv
// Handshake bundle of the immediate generator.
//   in_valid/in_ready/instr/mode : instruction side (valid/ready)
//   flush                        : discard pending prefix and output (branch taken)
//   out_valid/out_ready          : operand side (valid/ready)
//   immediate/prefixed           : extended operand, and whether it consumed a prefix
// slave = generator view, master = producer/consumer view.
interface gerador_de_imediato_if #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned DATA_W  = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [1:0]         mode;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  immediate;
  logic               prefixed;

  modport master (
    output in_valid, instr, mode, flush, out_ready,
    input  in_ready, out_valid, immediate, prefixed
  );

  modport slave (
    input  in_valid, instr, mode, flush, out_ready,
    output in_ready, out_valid, immediate, prefixed
  );
endinterface

// File: rtl/gerador_de_imediato_extensor_param.sv
// extensor_param: combinational sign/zero extender with a run-time width.
//   value     : right-aligned source bits (bits at and above width are ignored)
//   width     : number of meaningful bits in value, 1..DATA_W
//   sign_ext  : 1 = replicate bit width-1 upwards, 0 = fill with zeros
//   result    : DATA_W-bit extended value
module extensor_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WW     = 4
) (
  input  logic [DATA_W-1:0] value,
  input  logic [WW-1:0]     width,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  logic msb;
  logic fill;

  always_comb begin
    msb    = 1'b0;
    result = '0;
    // Select bit width-1 without a variable part-select.
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i + 1 == 32'(width)) msb = value[i];
    end
    fill = sign_ext & msb;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      result[i] = (i < 32'(width)) ? value[i] : fill;
    end
  end

endmodule

// File: rtl/gerador_de_imediato.sv
// gerador_de_imediato: pipelined immediate generator.
// Extends instr[IMM_W-1:0] to a DATA_W operand in one of four modes:
// sign, zero, branch offset (sign then <<1) and prefix (accumulates wide
// constants across several instructions). One registered output stage
// behind a valid/ready handshake.
//   clock    : rising-edge clock
//   reset_n  : synchronous reset, active low
//   bus      : slave side of gerador_de_imediato_if (input and output handshakes,
//              flush, immediate, prefixed)
module gerador_de_imediato
  import gerador_de_imediato_pkg::*;
#(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned IMM_W   = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  gerador_de_imediato_if.slave  bus
);

  localparam int unsigned LW = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pfx_q, pfx_d;
  logic [LW-1:0]     len_q, len_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              prefixed_q, prefixed_d;

  logic [IMM_W-1:0]  imm;
  logic              in_ready;
  logic              accept;
  logic              out_fire;
  logic [DATA_W-1:0] ext_value;
  logic [LW-1:0]     ext_width;
  logic              ext_sign;
  logic [DATA_W-1:0] ext_result;
  logic [DATA_W-1:0] operand;

  // Opcode bits above the immediate field belong to the decoder, not here.
  if (INSTR_W > IMM_W) begin : g_opcode
    logic unused_opcode;
    assign unused_opcode = ^bus.instr[INSTR_W-1:IMM_W];
  end

  // Operand preparation: with a prefix pending the value is {pfx, imm}
  // truncated to DATA_W, and the sign position moves up with the prefix length.
  always_comb begin
    imm      = bus.instr[IMM_W-1:0];
    in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    out_fire = out_valid_q && bus.out_ready;
    ext_sign = (bus.mode != MODE_ZEXT);
    if (state_q == ST_PFX) begin
      ext_value = (pfx_q << IMM_W) | DATA_W'(imm);
      ext_width = LW'(sat_len(32'(len_q), IMM_W, DATA_W));
    end else begin
      ext_value = DATA_W'(imm);
      ext_width = LW'(IMM_W);
    end
  end

  extensor_param #(
    .DATA_W (DATA_W),
    .WW     (LW)
  ) u_extensor (
    .value    (ext_value),
    .width    (ext_width),
    .sign_ext (ext_sign),
    .result   (ext_result)
  );

  always_comb begin
    operand = (bus.mode == MODE_BR) ? (ext_result << 1) : ext_result;
  end

  // Next-state: flush beats everything; otherwise retire the output on a
  // consumer handshake, then let an accepted input overwrite it. A prefix
  // never loads the output register, so out_valid falls if it retired.
  always_comb begin
    state_d     = state_q;
    pfx_d       = pfx_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    prefixed_d  = prefixed_q;

    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
      pfx_d       = '0;
      len_d       = '0;
    end else begin
      if (out_fire) out_valid_d = 1'b0;
      if (accept) begin
        if (bus.mode == MODE_PFX) begin
          state_d = ST_PFX;
          if (state_q == ST_PFX) begin
            pfx_d = (pfx_q << IMM_W) | DATA_W'(imm);
            len_d = LW'(sat_len(32'(len_q), IMM_W, DATA_W));
          end else begin
            pfx_d = DATA_W'(imm);
            len_d = LW'(IMM_W);
          end
        end else begin
          out_valid_d = 1'b1;
          imm_d       = operand;
          prefixed_d  = (state_q == ST_PFX);
          state_d     = ST_IDLE;
          pfx_d       = '0;
          len_d       = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pfx_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      prefixed_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pfx_q       <= pfx_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      prefixed_q  <= prefixed_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.immediate = imm_q;
  assign bus.prefixed  = prefixed_q;

endmodule
